// File: rtl/lcd_write_arbiter.sv
// Round-robin arbiter sharing one LCDWriter between NUM_CLIENTS sequencers.
// An owner keeps the writer until a write flagged last completes or its lock times out.
module lcd_write_arbiter #(
  parameter int NUM_CLIENTS  = 2,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int TIMER_W      = 10
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CLIENTS-1:0]   cl_req,
  input  logic [NUM_CLIENTS-1:0]   cl_rs,
  input  logic [8*NUM_CLIENTS-1:0] cl_value,
  input  logic [NUM_CLIENTS-1:0]   cl_last,
  output logic [NUM_CLIENTS-1:0]   cl_ack,
  output logic                     wreq,
  input  logic                     wack,
  output logic                     register,
  output logic [7:0]               value,
  output logic [1:0]               owner,
  output logic                     busy,
  output logic                     lock_tmo
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT_ACK = 3'd2,
    ACK      = 3'd3,
    HOLD     = 3'd4
  } state_t;

  state_t             state, state_d;
  logic [1:0]         owner_d;
  logic               register_d;
  logic [7:0]         value_d;
  logic               last_q, last_d;
  logic [TIMER_W-1:0] timer, timer_d;
  logic [3:0]         ack_pad;
  logic               lock_tmo_d;

  // Client buses padded to the 4-client maximum so a 2-bit index is always in range.
  logic [3:0]  req_pad, rs_pad, last_pad;
  logic [31:0] value_pad;

  assign req_pad   = 4'(cl_req);
  assign rs_pad    = 4'(cl_rs);
  assign last_pad  = 4'(cl_last);
  assign value_pad = 32'(cl_value);

  logic [2:0] sum;
  logic [1:0] cand;
  logic       found;
  logic       take;
  logic [1:0] lidx;

  always_comb begin
    state_d    = state;
    owner_d    = owner;
    register_d = register;
    value_d    = value;
    last_d     = last_q;
    timer_d    = timer;
    ack_pad    = 4'b0000;
    lock_tmo_d = 1'b0;
    sum        = 3'd0;
    cand       = 2'd0;
    found      = 1'b0;
    take       = 1'b0;
    lidx       = owner;

    case (state)
      IDLE: begin
        // Search starts just after the previous owner and wraps modulo NUM_CLIENTS.
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
          sum = {1'b0, owner} + 3'(k);
          if (sum >= 3'(NUM_CLIENTS)) sum = sum - 3'(NUM_CLIENTS);
          if (!found && req_pad[sum[1:0]]) begin
            found = 1'b1;
            cand  = sum[1:0];
          end
        end
        if (found) begin
          owner_d = cand;
          lidx    = cand;
          take    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (wack) begin
          ack_pad[owner] = 1'b1;
          state_d        = ACK;
        end
      end
      ACK: begin
        timer_d = '0;
        state_d = last_q ? IDLE : HOLD;
      end
      HOLD: begin
        if (req_pad[owner]) begin
          lidx    = owner;
          take    = 1'b1;
          state_d = ISSUE;
        end else if (timer == TIMER_W'(LOCK_TIMEOUT - 1)) begin
          lock_tmo_d = 1'b1;
          state_d    = IDLE;
        end else begin
          timer_d = timer + TIMER_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      register_d = rs_pad[lidx];
      value_d    = value_pad[{lidx, 3'b000} +: 8];
      last_d     = last_pad[lidx];
    end
  end

  // State and registered outputs; every output reflects the state being entered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= 2'(NUM_CLIENTS - 1);
      register <= 1'b0;
      value    <= 8'h00;
      timer    <= '0;
      wreq     <= 1'b0;
      cl_ack   <= '0;
      busy     <= 1'b0;
      lock_tmo <= 1'b0;
    end else begin
      state    <= state_d;
      owner    <= owner_d;
      register <= register_d;
      value    <= value_d;
      timer    <= timer_d;
      wreq     <= (state_d == ISSUE);
      cl_ack   <= ack_pad[NUM_CLIENTS-1:0];
      busy     <= (state_d != IDLE);
      lock_tmo <= lock_tmo_d;
    end
  end

  // The latched last flag is only read after a latch, so it needs no reset.
  always_ff @(posedge clock) begin
    last_q <= last_d;
  end

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed bench for lcd_write_arbiter: vector table plus hand-written burst,
// timeout, reset and spurious-ack sequences against a simple LCDWriter model.
module tb_lcd_write_arbiter;

  localparam int NC = 2;
  localparam int LT = 16;
  localparam int TW = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_c [2] = '{1'b0, 1'b0};
  logic        rs_c  [2] = '{1'b0, 1'b0};
  logic        last_c[2] = '{1'b0, 1'b0};
  logic [7:0]  val_c [2] = '{8'h00, 8'h00};
  logic [1:0]  cl_req, cl_rs, cl_last, cl_ack;
  logic [15:0] cl_value;
  logic        wreq, wack, register, busy, lock_tmo;
  logic [7:0]  value;
  logic [1:0]  owner;
  logic        mwack = 1'b0;
  logic        spur_wack = 1'b0;
  logic        auto_ack = 1'b1;

  assign cl_req   = {req_c[1], req_c[0]};
  assign cl_rs    = {rs_c[1], rs_c[0]};
  assign cl_last  = {last_c[1], last_c[0]};
  assign cl_value = {val_c[1], val_c[0]};
  assign wack     = mwack | spur_wack;

  lcd_write_arbiter #(
    .NUM_CLIENTS (NC),
    .LOCK_TIMEOUT(LT),
    .TIMER_W     (TW)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .cl_req  (cl_req),
    .cl_rs   (cl_rs),
    .cl_value(cl_value),
    .cl_last (cl_last),
    .cl_ack  (cl_ack),
    .wreq    (wreq),
    .wack    (wack),
    .register(register),
    .value   (value),
    .owner   (owner),
    .busy    (busy),
    .lock_tmo(lock_tmo)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Writer model: acknowledges 5 cycles after it sees wreq.
  initial begin
    forever begin
      @(posedge clock); #1;
      if (wreq && auto_ack) begin
        repeat (5) @(posedge clock);
        #1 mwack = 1'b1;
        @(posedge clock);
        #1 mwack = 1'b0;
      end
    end
  end

  // Bus monitor: logs every write, counts acks/timeouts, flags wide wreq or unstable data.
  int         ack_cnt[2] = '{0, 0};
  int         tmo_cnt = 0;
  int         wide_err = 0;
  int         stab_err = 0;
  logic       wreq_prev = 1'b0;
  logic       pend = 1'b0;
  logic [8:0] snap = 9'h000;
  logic [8:0] wlog[$];

  always @(negedge clock) begin
    if (reset) begin
      pend      <= 1'b0;
      wreq_prev <= 1'b0;
    end else begin
      if (wreq && wreq_prev) wide_err <= wide_err + 1;
      if (pend && !wreq && ({register, value} !== snap)) stab_err <= stab_err + 1;
      if (wack) pend <= 1'b0;
      if (wreq) begin
        wlog.push_back({register, value});
        snap <= {register, value};
        pend <= 1'b1;
      end
      if (cl_ack[0]) ack_cnt[0] <= ack_cnt[0] + 1;
      if (cl_ack[1]) ack_cnt[1] <= ack_cnt[1] + 1;
      if (lock_tmo) tmo_cnt <= tmo_cnt + 1;
      wreq_prev <= wreq;
    end
  end

  // One client write: hold the request until cl_ack, then release it.
  task automatic client_write(input logic c, input logic rs, input logic [7:0] v, input logic last);
    logic got;
    got       = 1'b0;
    req_c[c]  = 1'b1;
    rs_c[c]   = rs;
    val_c[c]  = v;
    last_c[c] = last;
    for (int n = 0; n < 200 && !got; n++) begin
      @(posedge clock); #1;
      if (cl_ack[c]) got = 1'b1;
    end
    req_c[c] = 1'b0;
    check("client_ack_seen", 32'(got), 32'd1);
  endtask

  task automatic do_reset();
    req_c[0] = 1'b0;
    req_c[1] = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic       c;
    logic       rs;
    logic [7:0] val;
    logic       last;
    logic       exp_reg;
    logic [7:0] exp_val;
    logic [1:0] exp_owner;
  } vec_t;

  vec_t vt[4];

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int         base;
    int         a0;
    int         n;
    logic       got;
    logic [31:0] tmo0;

    vt[0] = '{1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 8'h01, 2'd0};
    vt[1] = '{1'b1, 1'b1, 8'h41, 1'b1, 1'b1, 8'h41, 2'd1};
    vt[2] = '{1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 8'hFF, 2'd1};
    vt[3] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 2'd0};

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_wreq", 32'(wreq), 32'd0);
    check("rst_cl_ack", 32'(cl_ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd1);
    check("rst_register", 32'(register), 32'd0);
    check("rst_value", 32'(value), 32'h00);
    check("rst_lock_tmo", 32'(lock_tmo), 32'd0);
    reset = 1'b0;

    // Single write from client 0 with detailed latency
    req_c[0] = 1'b1; rs_c[0] = 1'b0; val_c[0] = 8'h01; last_c[0] = 1'b1;
    check("t1_pre_wreq", 32'(wreq), 32'd0);
    @(posedge clock); #1;
    check("t1_wreq", 32'(wreq), 32'd1);
    check("t1_owner", 32'(owner), 32'd0);
    check("t1_register", 32'(register), 32'd0);
    check("t1_value", 32'(value), 32'h01);
    check("t1_busy", 32'(busy), 32'd1);
    @(posedge clock); #1;
    check("t1_wreq_pulse", 32'(wreq), 32'd0);
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(posedge clock); #1;
      if (cl_ack[0]) got = 1'b1;
    end
    req_c[0] = 1'b0;
    check("t1_ack", 32'(got), 32'd1);
    @(posedge clock); #1;
    check("t1_ack_cnt", 32'(ack_cnt[0]), 32'd1);
    check("t1_idle_busy", 32'(busy), 32'd0);
    check("t1_ack_drop", 32'(cl_ack), 32'd0);

    // Vector table: isolated single writes
    for (int i = 0; i < 4; i++) begin
      base = wlog.size();
      a0   = ack_cnt[0] + ack_cnt[1];
      client_write(vt[i].c, vt[i].rs, vt[i].val, vt[i].last);
      @(posedge clock); #1;
      check("vec_busy", 32'(busy), 32'd0);
      check("vec_nwrites", 32'(wlog.size()), 32'(base + 1));
      check("vec_write", 32'(wlog[base]), 32'({vt[i].exp_reg, vt[i].exp_val}));
      check("vec_owner", 32'(owner), 32'(vt[i].exp_owner));
      check("vec_value_held", 32'(value), 32'(vt[i].exp_val));
      check("vec_acks", 32'(ack_cnt[0] + ack_cnt[1]), 32'(a0 + 1));
    end

    // Simultaneous requests: round-robin from owner+1
    do_reset();
    base = wlog.size();
    fork
      client_write(1'b0, 1'b1, 8'h30, 1'b1);
      client_write(1'b1, 1'b1, 8'h31, 1'b1);
    join
    fork
      client_write(1'b0, 1'b1, 8'h32, 1'b1);
      client_write(1'b1, 1'b1, 8'h33, 1'b1);
    join
    check("rr_nwrites", 32'(wlog.size()), 32'(base + 4));
    check("rr_w0", 32'(wlog[base]), 32'h130);
    check("rr_w1", 32'(wlog[base + 1]), 32'h131);
    check("rr_w2", 32'(wlog[base + 2]), 32'h132);
    check("rr_w3", 32'(wlog[base + 3]), 32'h133);

    // Burst lock: client 1 waits for the whole burst
    do_reset();
    base = wlog.size();
    fork
      begin
        client_write(1'b0, 1'b0, 8'h84, 1'b0);
        client_write(1'b0, 1'b1, 8'h48, 1'b0);
        client_write(1'b0, 1'b1, 8'h69, 1'b1);
      end
      client_write(1'b1, 1'b1, 8'hAA, 1'b1);
    join
    check("burst_nwrites", 32'(wlog.size()), 32'(base + 4));
    check("burst_w0", 32'(wlog[base]), 32'h084);
    check("burst_w1", 32'(wlog[base + 1]), 32'h148);
    check("burst_w2", 32'(wlog[base + 2]), 32'h169);
    check("burst_w3", 32'(wlog[base + 3]), 32'h1AA);

    // Lock timeout: owner stalls after last=0
    do_reset();
    tmo0 = 32'(tmo_cnt);
    fork
      begin
        client_write(1'b0, 1'b0, 8'h80, 1'b0);
        n   = 0;
        got = 1'b0;
        while (n < 40 && !got) begin
          @(posedge clock); #1;
          n++;
          if (lock_tmo) got = 1'b1;
        end
        check("tmo_seen", 32'(got), 32'd1);
        check("tmo_delay", 32'(n), 32'd17);
        @(posedge clock); #1;
        check("tmo_width", 32'(lock_tmo), 32'd0);
        check("tmo_grant_owner", 32'(owner), 32'd1);
        check("tmo_grant_wreq", 32'(wreq), 32'd1);
        check("tmo_grant_value", 32'(value), 32'hC1);
      end
      client_write(1'b1, 1'b1, 8'hC1, 1'b1);
    join
    check("tmo_count", 32'(tmo_cnt), tmo0 + 32'd1);

    // Reset during WAIT_ACK abandons the transfer
    do_reset();
    auto_ack  = 1'b0;
    a0        = ack_cnt[0];
    req_c[0]  = 1'b1; rs_c[0] = 1'b1; val_c[0] = 8'h5A; last_c[0] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clock); #1;
      if (wreq) got = 1'b1;
    end
    check("rwa_wreq_seen", 32'(got), 32'd1);
    repeat (2) @(posedge clock);
    #1;
    check("rwa_busy_before", 32'(busy), 32'd1);
    check("rwa_value_before", 32'(value), 32'h5A);
    reset = 1'b1;
    #1;
    check("rwa_wreq", 32'(wreq), 32'd0);
    check("rwa_cl_ack", 32'(cl_ack), 32'd0);
    check("rwa_busy", 32'(busy), 32'd0);
    check("rwa_register", 32'(register), 32'd0);
    check("rwa_value", 32'(value), 32'h00);
    check("rwa_owner", 32'(owner), 32'd1);
    check("rwa_lock_tmo", 32'(lock_tmo), 32'd0);
    req_c[0] = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    check("rwa_no_ack", 32'(ack_cnt[0]), 32'(a0));
    check("rwa_idle", 32'(busy), 32'd0);
    auto_ack = 1'b1;

    // Spurious wack in IDLE
    a0   = ack_cnt[0] + ack_cnt[1];
    base = wlog.size();
    spur_wack = 1'b1;
    @(posedge clock); #1;
    spur_wack = 1'b0;
    check("sp_idle_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clock);
    #1;
    check("sp_idle_acks", 32'(ack_cnt[0] + ack_cnt[1]), 32'(a0));
    check("sp_idle_busy2", 32'(busy), 32'd0);
    check("sp_idle_nowrite", 32'(wlog.size()), 32'(base));

    // Spurious wack in HOLD
    client_write(1'b0, 1'b1, 8'h41, 1'b0);
    a0 = ack_cnt[0] + ack_cnt[1];
    @(posedge clock); #1;
    check("sp_hold_busy", 32'(busy), 32'd1);
    spur_wack = 1'b1;
    @(posedge clock); #1;
    spur_wack = 1'b0;
    @(posedge clock); #1;
    check("sp_hold_acks", 32'(ack_cnt[0] + ack_cnt[1]), 32'(a0 + 1));
    check("sp_hold_busy2", 32'(busy), 32'd1);
    check("sp_hold_wreq", 32'(wreq), 32'd0);
    check("sp_hold_cl_ack", 32'(cl_ack), 32'd0);
    client_write(1'b0, 1'b1, 8'h42, 1'b1);
    check("sp_hold_nwrites", 32'(wlog.size()), 32'(base + 2));
    check("sp_hold_w1", 32'(wlog[base + 1]), 32'h142);
    @(posedge clock); #1;
    check("sp_hold_end_idle", 32'(busy), 32'd0);

    check("wreq_single_cycle", 32'(wide_err), 32'd0);
    check("data_stable", 32'(stab_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
